// File: rtl/lda_cmd_scheduler.sv
// Command scheduler: queues line/clear commands in a small FIFO and executes them in order,
// handing lines to the line datapath and sweeping the canvas itself for clears.
module lda_cmd_scheduler #(
    parameter int DEPTH = 4,
    parameter int W     = 336,
    parameter int H     = 210,
    parameter int XW    = 9,
    parameter int YW    = 8,
    parameter int CW    = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic                   i_cmd_clear,
    input  logic [XW-1:0]          i_cmd_x0,
    input  logic [XW-1:0]          i_cmd_x1,
    input  logic [YW-1:0]          i_cmd_y0,
    input  logic [YW-1:0]          i_cmd_y1,
    input  logic [CW-1:0]          i_cmd_color,
    output logic                   o_line_start,
    output logic [XW-1:0]          o_line_x0,
    output logic [XW-1:0]          o_line_x1,
    output logic [YW-1:0]          o_line_y0,
    output logic [YW-1:0]          o_line_y1,
    output logic [CW-1:0]          o_line_color,
    input  logic                   i_line_done,
    output logic                   o_pix_sel,
    output logic                   o_clr_plot,
    output logic [XW-1:0]          o_clr_x,
    output logic [YW-1:0]          o_clr_y,
    output logic [CW-1:0]          o_clr_color,
    output logic                   o_cmd_done,
    output logic                   o_busy,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int EW   = 1 + 2 * XW + 2 * YW + CW;
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
    localparam logic [XW-1:0]   X_LAST  = XW'(W - 1);
    localparam logic [YW-1:0]   Y_LAST  = YW'(H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPATCH,
        S_DRAW,
        S_CLEAR,
        S_FINISH
    } state_t;

    state_t state_reg, state_next;

    logic [EW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNTW-1:0] count_reg;
    logic            push, pop;
    logic [EW-1:0]   head;

    logic            cur_clear_reg;
    logic [XW-1:0]   cur_x0_reg, cur_x1_reg;
    logic [YW-1:0]   cur_y0_reg, cur_y1_reg;
    logic [CW-1:0]   cur_color_reg;
    logic [XW-1:0]   sweep_x_reg;
    logic [YW-1:0]   sweep_y_reg;
    logic            sweep_last;

    // Ready looks only at the registered count, so a full FIFO refuses a push even while popping.
    assign o_cmd_ready = (count_reg < DEPTH_C);
    assign push        = i_cmd_valid & o_cmd_ready;
    assign pop         = (state_reg == S_IDLE) && (count_reg != '0);
    assign head        = mem[rd_ptr_reg];
    assign sweep_last  = (sweep_x_reg == X_LAST) && (sweep_y_reg == Y_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {i_cmd_clear, i_cmd_x0, i_cmd_y0, i_cmd_x1, i_cmd_y1, i_cmd_color};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNTW'(1);
                2'b01:   count_reg <= count_reg - CNTW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:     if (count_reg != '0) state_next = S_DISPATCH;
            S_DISPATCH: state_next = cur_clear_reg ? S_CLEAR : S_DRAW;
            S_DRAW:     if (i_line_done) state_next = S_FINISH;
            S_CLEAR:    if (sweep_last) state_next = S_FINISH;
            S_FINISH:   state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_clear_reg <= 1'b0;
            cur_x0_reg    <= '0;
            cur_y0_reg    <= '0;
            cur_x1_reg    <= '0;
            cur_y1_reg    <= '0;
            cur_color_reg <= '0;
            sweep_x_reg   <= '0;
            sweep_y_reg   <= '0;
        end else begin
            if (pop) begin
                {cur_clear_reg, cur_x0_reg, cur_y0_reg, cur_x1_reg, cur_y1_reg, cur_color_reg} <= head;
            end
            if (state_reg == S_DISPATCH) begin
                sweep_x_reg <= '0;
                sweep_y_reg <= '0;
            end else if (state_reg == S_CLEAR) begin
                // Raster order, x fastest; the counter parks at (0,0) after the last plot.
                if (sweep_x_reg == X_LAST) begin
                    sweep_x_reg <= '0;
                    sweep_y_reg <= sweep_last ? '0 : sweep_y_reg + 1'b1;
                end else begin
                    sweep_x_reg <= sweep_x_reg + 1'b1;
                end
            end
        end
    end

    assign o_line_start = (state_reg == S_DISPATCH) && !cur_clear_reg;
    assign o_line_x0    = cur_x0_reg;
    assign o_line_x1    = cur_x1_reg;
    assign o_line_y0    = cur_y0_reg;
    assign o_line_y1    = cur_y1_reg;
    assign o_line_color = cur_color_reg;
    assign o_pix_sel    = (state_reg == S_CLEAR);
    assign o_clr_plot   = (state_reg == S_CLEAR);
    assign o_clr_x      = sweep_x_reg;
    assign o_clr_y      = sweep_y_reg;
    assign o_clr_color  = cur_color_reg;
    assign o_cmd_done   = (state_reg == S_FINISH);
    assign o_busy       = (state_reg != S_IDLE) || (count_reg != '0);
    assign o_count      = count_reg;

endmodule

// File: tb/tb_lda_cmd_scheduler.sv
// Directed bench for lda_cmd_scheduler on a small 8x4 canvas with a 4-entry FIFO.
module tb_lda_cmd_scheduler;
    localparam int DEPTH = 4;
    localparam int W     = 8;
    localparam int H     = 4;
    localparam int XW    = 9;
    localparam int YW    = 8;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic          i_cmd_clear = 1'b0;
    logic [XW-1:0] i_cmd_x0 = '0, i_cmd_x1 = '0;
    logic [YW-1:0] i_cmd_y0 = '0, i_cmd_y1 = '0;
    logic [CW-1:0] i_cmd_color = '0;
    logic          o_line_start;
    logic [XW-1:0] o_line_x0, o_line_x1;
    logic [YW-1:0] o_line_y0, o_line_y1;
    logic [CW-1:0] o_line_color;
    logic          i_line_done = 1'b0;
    logic          o_pix_sel, o_clr_plot;
    logic [XW-1:0] o_clr_x;
    logic [YW-1:0] o_clr_y;
    logic [CW-1:0] o_clr_color;
    logic          o_cmd_done, o_busy;
    logic [2:0]    o_count;

    int total = 0;
    int bad   = 0;

    lda_cmd_scheduler #(
        .DEPTH(DEPTH), .W(W), .H(H), .XW(XW), .YW(YW), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_clear(i_cmd_clear),
        .i_cmd_x0(i_cmd_x0), .i_cmd_x1(i_cmd_x1), .i_cmd_y0(i_cmd_y0), .i_cmd_y1(i_cmd_y1),
        .i_cmd_color(i_cmd_color),
        .o_line_start(o_line_start), .o_line_x0(o_line_x0), .o_line_x1(o_line_x1),
        .o_line_y0(o_line_y0), .o_line_y1(o_line_y1), .o_line_color(o_line_color),
        .i_line_done(i_line_done),
        .o_pix_sel(o_pix_sel), .o_clr_plot(o_clr_plot), .o_clr_x(o_clr_x), .o_clr_y(o_clr_y),
        .o_clr_color(o_clr_color), .o_cmd_done(o_cmd_done), .o_busy(o_busy), .o_count(o_count)
    );

    always #5 clk = ~clk;

    // Grouped views of outputs for compact comparisons.
    logic [36:0] line_bus;
    logic [8:0]  ctrl_bus;
    logic [56:0] data_bus;
    logic [19:0] clr_bus;
    assign line_bus = {o_line_x0, o_line_y0, o_line_x1, o_line_y1, o_line_color};
    assign ctrl_bus = {o_cmd_ready, o_line_start, o_pix_sel, o_clr_plot, o_cmd_done, o_busy, o_count};
    assign data_bus = {line_bus, o_clr_x, o_clr_y, o_clr_color};
    assign clr_bus  = {o_clr_plot, o_pix_sel, o_clr_x, o_clr_y, o_cmd_done};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [36:0] lf(input int n);
        return {9'(n * 3), 8'(n * 5), 9'(n * 7), 8'(n + 100), 3'(n)};
    endfunction

    task automatic set_cmd(input logic clr, input logic [36:0] f);
        i_cmd_clear = clr;
        {i_cmd_x0, i_cmd_y0, i_cmd_x1, i_cmd_y1, i_cmd_color} = f;
        i_cmd_valid = 1'b1;
    endtask

    // Entered in an o_cmd_done cycle; expects the next line start two cycles later.
    task automatic serve_line(input string tag, input logic [36:0] exp);
        int n;
        n = 0;
        do begin
            tick;
            n++;
        end while (!o_line_start && n < 20);
        chk({tag, "_gap"}, 64'(n), 64'(2));
        chk({tag, "_fields"}, 64'(line_bus), 64'(exp));
        tick;
        i_line_done = 1'b1;
        tick;
        i_line_done = 1'b0;
        chk({tag, "_done"}, 64'(o_cmd_done), 64'(1));
        $display("line %s completed x0=%0d y0=%0d", tag, o_line_x0, o_line_y0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick;
        tick;
        chk("rst_ctrl", 64'(ctrl_bus), 64'({1'b1, 5'b0, 3'd0}));
        chk("rst_data", 64'(data_bus), 64'(0));
        reset = 1'b0;
        tick;

        // Single line: start 2 cycles after accept, done 7 cycles after start
        set_cmd(1'b0, {9'd10, 8'd20, 9'd100, 8'd50, 3'd5});
        tick;
        i_cmd_valid = 1'b0;
        chk("l1_start_k1", 64'(o_line_start), 64'(0));
        chk("l1_count_k1", 64'(o_count), 64'(1));
        tick;
        chk("l1_start_k2", 64'(o_line_start), 64'(1));
        chk("l1_fields", 64'(line_bus), 64'({9'd10, 8'd20, 9'd100, 8'd50, 3'd5}));
        for (int i = 0; i < 6; i++) tick;
        chk("l1_start_low", 64'(o_line_start), 64'(0));
        tick;
        i_line_done = 1'b1;
        chk("l1_nodone_yet", 64'(o_cmd_done), 64'(0));
        tick;
        i_line_done = 1'b0;
        chk("l1_done", 64'(o_cmd_done), 64'(1));
        chk("l1_busy_fin", 64'(o_busy), 64'(1));
        tick;
        chk("l1_done_once", 64'(o_cmd_done), 64'(0));
        chk("l1_busy_low", 64'(o_busy), 64'(0));
        chk("l1_hold", 64'(line_bus), 64'({9'd10, 8'd20, 9'd100, 8'd50, 3'd5}));
        $display("line L1 completed");

        // Spurious done while idle
        i_line_done = 1'b1;
        tick;
        i_line_done = 1'b0;
        chk("sp_idle_done", 64'(o_cmd_done), 64'(0));
        chk("sp_idle_busy", 64'(o_busy), 64'(0));

        // Clear colour 0 with spurious done in dispatch and mid-sweep
        set_cmd(1'b1, lf(9));
        i_cmd_color = 3'd0;
        tick;
        i_cmd_valid = 1'b0;
        tick;
        chk("clr_disp_start", 64'(o_line_start), 64'(0));
        chk("clr_disp_sel", 64'(o_pix_sel), 64'(0));
        i_line_done = 1'b1;
        for (int i = 0; i < W * H; i++) begin
            tick;
            i_line_done = (i == 5);
            chk($sformatf("clr_plot%0d", i), 64'(clr_bus),
                64'({1'b1, 1'b1, 9'(i % W), 8'(i / W), 1'b0}));
        end
        i_line_done = 1'b0;
        chk("clr_color", 64'(o_clr_color), 64'(0));
        tick;
        chk("clr_finish", 64'({o_cmd_done, o_clr_plot, o_pix_sel}), 64'(3'b100));
        tick;
        chk("clr_after", 64'({o_cmd_done, o_pix_sel, o_busy}), 64'(3'b000));
        $display("clear colour 0 completed");

        // Fill, backpressure and push refused at full during a pop
        set_cmd(1'b0, lf(1));
        tick;
        set_cmd(1'b0, lf(2));
        chk("fill_ready_b", 64'(o_cmd_ready), 64'(1));
        tick;
        chk("fill_count_b", 64'(o_count), 64'(1));
        chk("fill_start_a", 64'({o_line_start, line_bus}), 64'({1'b1, lf(1)}));
        set_cmd(1'b0, lf(3));
        tick;
        set_cmd(1'b0, lf(4));
        tick;
        set_cmd(1'b0, lf(5));
        chk("fill_count3", 64'(o_count), 64'(3));
        tick;
        chk("fill_count4", 64'(o_count), 64'(4));
        chk("fill_notready", 64'(o_cmd_ready), 64'(0));
        set_cmd(1'b0, lf(6));
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("fill_stall%0d", i), 64'({o_count, o_cmd_ready}), 64'({3'd4, 1'b0}));
        end
        i_line_done = 1'b1;
        tick;
        i_line_done = 1'b0;
        chk("fill_done_a", 64'({o_cmd_done, o_count, o_cmd_ready}), 64'({1'b1, 3'd4, 1'b0}));
        $display("line A completed");
        tick;
        chk("full_pop_pre", 64'({o_count, o_cmd_ready}), 64'({3'd4, 1'b0}));
        tick;
        chk("full_pop_refused", 64'({o_count, o_cmd_ready}), 64'({3'd3, 1'b1}));
        chk("fill_start_b", 64'({o_line_start, line_bus}), 64'({1'b1, lf(2)}));
        tick;
        i_cmd_valid = 1'b0;
        chk("fill_f_accepted", 64'(o_count), 64'(4));
        i_line_done = 1'b1;
        tick;
        i_line_done = 1'b0;
        chk("fill_done_b", 64'(o_cmd_done), 64'(1));
        $display("line B completed");
        serve_line("C", lf(3));
        serve_line("D", lf(4));
        serve_line("E", lf(5));
        serve_line("F", lf(6));
        tick;
        chk("fill_empty", 64'({o_busy, o_count}), 64'(0));

        // Reset mid-clear with two lines queued
        set_cmd(1'b1, lf(0));
        i_cmd_color = 3'd6;
        tick;
        set_cmd(1'b0, lf(7));
        tick;
        set_cmd(1'b0, lf(8));
        tick;
        i_cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        chk("mid_state", 64'({o_pix_sel, o_count, o_clr_color, o_busy}), 64'({1'b1, 3'd2, 3'd6, 1'b1}));
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_ctrl", 64'(ctrl_bus), 64'({1'b1, 5'b0, 3'd0}));
        chk("mid_rst_data", 64'(data_bus), 64'(0));
        tick;
        reset = 1'b0;
        begin
            int dones;
            int busys;
            dones = 0;
            busys = 0;
            for (int i = 0; i < 40; i++) begin
                tick;
                if (o_cmd_done) dones++;
                if (o_busy || o_count != 0) busys++;
            end
            chk("post_rst_dones", 64'(dones), 64'(0));
            chk("post_rst_busy", 64'(busys), 64'(0));
        end
        $display("reset mid-clear handled");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
